fetch_unit: RTL and testbench

//  Instruction fetch stage; sits directly upstream of the decoder and supplies its 32-bit instruction word.
//  - Holds the PC and issues word requests to instruction memory over a valid/ready request channel.
//  - Buffers in-order responses in a DEPTH-entry queue and presents {instr, pc} to decode with valid/ready.
//  - Handles branch/jump redirects: flushes the queue and discards in-flight responses.

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, DEPTH-entry in-order queue, redirect flush.
// Optional FETCH_PERF_CNT_EN adds the fetch_count port counting instructions delivered to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   instr_d [DEPTH];
  logic [31:0]   epc_q   [DEPTH];
  logic [31:0]   epc_d   [DEPTH];

  logic req_hs;
  logic pop;
  logic push;
  logic unused_redirect_lsb;

  // Both channels transfer on a cycle where valid and ready are high together.
  // Requests only issue when queue entries plus in-flight requests leave a free slot.
  assign imem_req_valid = !rst && (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign if_valid = (count_q != '0);
  assign if_instr = instr_q[head_q];
  assign if_pc    = epc_q[head_q];
  assign pop      = if_valid && if_ready;
  assign push     = imem_rsp_valid && (drop_q == '0);

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    drop_d   = drop_q;
    instr_d  = instr_q;
    epc_d    = epc_q;
    outst_d  = outst_q + CW'(req_hs) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      pc_d     = {redirect_pc[31:2], 2'b00};
      rsp_pc_d = {redirect_pc[31:2], 2'b00};
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      drop_d   = outst_d;
    end else begin
      if (req_hs) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          instr_d[tail_q] = imem_rsp_data;
          epc_d[tail_q]   = rsp_pc_q;
          tail_d          = tail_q + PW'(1);
          rsp_pc_d        = rsp_pc_q + 32'd4;
        end
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        epc_q[i]   <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      instr_q  <= instr_d;
      epc_q    <= epc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  // Pops in a redirect cycle are discarded, so they are not delivered.
  always_comb begin
    fetch_count_d = fetch_count_q + 32'(pop && !redirect_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

  a_rsp_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (outst_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order imem model with variable latency, expected-stream scoreboard,
// directed scenarios followed by a randomized run with redirects and mid-run resets.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned hs_cnt = 0;
  int unsigned pops_since = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] key = '0;
  logic [31:0] model_pc = RESET_PC;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;
  pend_t       pend_q[$];
  int unsigned last_due = 0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ key;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected delivery stream: consecutive words from the last reset/redirect target.
  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back({data_of(model_pc), model_pc});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic cycle_begin();
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    topup();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    exp_q.delete();
    model_pc = target & 32'hFFFF_FFFC;
    topup();
  endtask

  task automatic release_rst();
    cycle_begin();
    rst = 1'b0;
    exp_q.delete();
    model_pc   = RESET_PC;
    pops_since = 0;
    topup();
  endtask

  task automatic do_reset(input logic [31:0] new_key);
    cycle_begin();
    rst = 1'b1;
    if_ready = 1'b0;
    imem_req_ready = 1'b0;
    repeat (2) cycle_begin();
    key = new_key;
    release_rst();
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (!if_valid && n < budget) begin
      cycle_begin();
      n++;
    end
    if (!if_valid) begin
      total++;
      bad++;
      $display("FAIL %s: if_valid timeout after %0d cycles", name, budget);
    end
  endtask

  // Instruction memory: accepts on handshake, returns in order after lat_min..lat_max cycles.
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data_of(pend_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    @(negedge clk);
    if (rst) begin
      pend_q.delete();
      last_due = 0;
    end else begin
      if (imem_rsp_valid) void'(pend_q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        pend_t p;
        int unsigned d;
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d < last_due) d = last_due;
        last_due = d;
        p.addr = imem_req_addr;
        p.due  = d;
        pend_q.push_back(p);
        hs_cnt++;
      end
    end
  end

  // Monitor: compares every delivered instruction against the expected stream.
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  initial forever begin
    @(negedge clk);
    if (!rst && if_valid && if_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got pc %h with no expected entry", if_pc);
      end else begin
        check("pop_instr_pc", {if_instr, if_pc}, exp_q.pop_front());
      end
      pops_since++;
    end
    if (!rst && prev_pend) begin
      check("req_hold", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, prev_addr});
    end
    prev_pend = !rst && imem_req_valid && !imem_req_ready && !redirect_valid;
    prev_addr = imem_req_addr;
  end

  initial begin
    int first_v;
    int nvalid;
    int n;
    int guard;
    int unsigned hs0;
    int unsigned p0;
    logic [31:0] addr0;
    logic found;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_if_valid", {63'd0, if_valid}, 64'd0);
    check("rst_if_instr", {32'd0, if_instr}, 64'd0);
    check("rst_if_pc", {32'd0, if_pc}, 64'd0);
    check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("rst_req_addr", {32'd0, imem_req_addr}, {32'd0, RESET_PC});
`ifdef FETCH_PERF_CNT_EN
    check("rst_fetch_count", {32'd0, fetch_count}, 64'd0);
`endif

    // 1: streaming, addr-as-data, one per clock after two startup cycles
    key = '0;
    release_rst();
    if_ready = 1'b1;
    imem_req_ready = 1'b1;
    first_v = -1;
    nvalid = 0;
    for (int i = 1; i < 20; i++) begin
      cycle_begin();
      if (if_valid) begin
        nvalid++;
        if (first_v < 0) first_v = i;
      end
    end
    check("startup_latency", 64'(first_v), 64'd2);
    check("stream_rate", 64'(nvalid), 64'd18);

    // 2: decode stalled, credit caps requests at DEPTH
    do_reset(32'h0);
    if_ready = 1'b0;
    imem_req_ready = 1'b1;
    hs0 = hs_cnt;
    repeat (10) cycle_begin();
    check("credit_reqs", 64'(hs_cnt - hs0), 64'(DEPTH));
    check("credit_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("credit_if_valid", {63'd0, if_valid}, 64'd1);
    if_ready = 1'b1;
    repeat (10) cycle_begin();
    total++;
    if (pops_since < 4) begin
      bad++;
      $display("FAIL credit_drain: got %0d pops expected at least 4", pops_since);
    end

    // 3: 3-cycle memory, redirect with two requests in flight
    lat_min = 3;
    lat_max = 3;
    do_reset(32'h1357_9bdf);
    if_ready = 1'b1;
    imem_req_ready = 1'b1;
    cycle_begin();
    cycle_begin();
    imem_req_ready = 1'b0;
    do_redirect(32'h100);
    cycle_begin();
    imem_req_ready = 1'b1;
    wait_valid(40, "redir_inflight");
    check("redir_inflight_pc", {32'd0, if_pc}, 64'h100);
    check("redir_inflight_instr", {32'd0, if_instr}, {32'd0, data_of(32'h100)});

    // 4: redirect coinciding with a response and a pop
    lat_min = 1;
    lat_max = 1;
    do_reset(32'h0f0f_0000);
    if_ready = 1'b1;
    imem_req_ready = 1'b1;
    repeat (8) cycle_begin();
    found = 1'b0;
    guard = 0;
    while (!found && guard < 20) begin
      if (imem_rsp_valid && if_valid) found = 1'b1;
      else begin
        cycle_begin();
        guard++;
      end
    end
    check("redir_same_found", {63'd0, found}, 64'd1);
    do_redirect(32'h203);
    cycle_begin();
    check("redir_same_flush", {63'd0, if_valid}, 64'd0);
    wait_valid(20, "redir_same");
    check("redir_same_pc", {32'd0, if_pc}, 64'h200);

    // 5: memory stalls, request must hold
    repeat (4) cycle_begin();
    imem_req_ready = 1'b0;
    addr0 = imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cycle_begin();
      check("stall_hold", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, addr0});
    end
    cycle_begin();
    imem_req_ready = 1'b1;
    cycle_begin();
    check("stall_advance", {32'd0, imem_req_addr}, {32'd0, addr0 + 32'd4});
    repeat (10) cycle_begin();

    // 6: delivered count across a flush, then reset mid-run
    do_reset(32'h2468_0000);
    imem_req_ready = 1'b1;
    n = 0;
    guard = 0;
    while (n < 10 && guard < 80) begin
      cycle_begin();
      if_ready = if_valid;
      if (if_valid) n++;
      guard++;
    end
    cycle_begin();
    if_ready = 1'b0;
    repeat (6) cycle_begin();
    check("count_pops", 64'(pops_since), 64'd10);
    check("count_full", {63'd0, if_valid}, 64'd1);
`ifdef FETCH_PERF_CNT_EN
    check("count_before_flush", {32'd0, fetch_count}, 64'd10);
`endif
    do_redirect(32'h400);
    cycle_begin();
    check("count_flush_valid", {63'd0, if_valid}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    check("count_after_flush", {32'd0, fetch_count}, 64'd10);
`endif
    if_ready = 1'b1;
    repeat (8) cycle_begin();
    rst = 1'b1;
    #1;
    check("midrst_if_valid", {63'd0, if_valid}, 64'd0);
    check("midrst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("midrst_addr", {32'd0, imem_req_addr}, {32'd0, RESET_PC});
`ifdef FETCH_PERF_CNT_EN
    check("midrst_fetch_count", {32'd0, fetch_count}, 64'd0);
`endif
    repeat (2) cycle_begin();
    key = 32'h0;
    release_rst();

    // Randomized run
    lat_max = 4;
    key = $urandom;
    do_reset(key);
    for (int i = 0; i < 3000; i++) begin
      cycle_begin();
      imem_req_ready = ($urandom_range(3, 0) != 0);
      if_ready = ($urandom_range(2, 0) != 0);
      if ($urandom_range(39, 0) == 0) do_redirect($urandom);
      if ($urandom_range(799, 0) == 0) do_reset($urandom);
    end
    cycle_begin();
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    p0 = pops_since;
    repeat (30) cycle_begin();
    check("rand_drain_progress", {63'd0, (pops_since - p0) >= 20}, 64'd1);
`ifdef FETCH_PERF_CNT_EN
    check("rand_fetch_count", {32'd0, fetch_count}, {32'd0, 32'(pops_since)});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
